// File: rtl/sprite_line_selector.sv
// Per-scanline sprite selector: scans OAM into NUM_SLOTS slots, then answers x queries
// lowest OAM index first. Optional Y-flip of dy is enabled by defining SPRITE_YFLIP_EN.
module sprite_line_selector #(
    parameter  int NUM_SLOTS   = 10,
    parameter  int OAM_ENTRIES = 40,
    localparam int AW          = $clog2(2 * OAM_ENTRIES),
    localparam int IW          = (OAM_ENTRIES > 1) ? $clog2(OAM_ENTRIES) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    ly,
    input  logic          tall,
    output logic [AW-1:0] oam_addr,
    input  logic [15:0]   oam_d_in,
    output logic          scan_done,
    output logic          overflow,
    input  logic [7:0]    q_x,
    input  logic          q_take,
    output logic          hit,
    output logic [14:0]   hit_data,
    output logic [IW-1:0] hit_index
);

    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_READY} state_t;

    state_t               r_state, w_next_state;
    logic [AW-1:0]        r_addr;
    logic [7:0]           r_y, r_x_lat;
    logic                 r_overflow;
    logic [NUM_SLOTS-1:0] r_valid;
    logic [7:0]           r_slot_x    [NUM_SLOTS];
    logic [14:0]          r_slot_data [NUM_SLOTS];
    logic [IW-1:0]        r_slot_idx  [NUM_SLOTS];

    logic [7:0]    w_dy;
    logic [3:0]    w_dy_sel;
    logic [7:0]    w_tile;
    logic [14:0]   w_entry;
    logic [IW-1:0] w_entry_idx;
    logic          w_visible, w_last, w_latch, w_eval;
    logic          w_have_free, w_hit;
    logic [SW-1:0] w_free_idx, w_win_idx;
    logic          w_unused_attrs;

    assign w_unused_attrs = ^oam_d_in[11:8];

    // The odd OAM word arrives while the latched even word holds Y and X.
    assign w_dy      = ly - (r_y - 8'd16);
    assign w_visible = tall ? (w_dy < 8'd16) : (w_dy < 8'd8);

    always_comb begin
        w_dy_sel = w_dy[3:0];
`ifdef SPRITE_YFLIP_EN
        if (oam_d_in[14]) begin
            if (tall) w_dy_sel = ~w_dy[3:0];
            else      w_dy_sel = {w_dy[3], ~w_dy[2:0]};
        end
`endif
    end

    assign w_tile      = tall ? {oam_d_in[7:1], w_dy_sel[3]} : oam_d_in[7:0];
    assign w_entry     = {w_dy_sel[2:0], w_tile, oam_d_in[15:12]};
    assign w_entry_idx = IW'(r_addr >> 1);
    assign w_last      = (r_addr == AW'(2 * OAM_ENTRIES - 1));
    assign w_latch     = (r_state == ST_SCAN) && !r_addr[0] && !start;
    assign w_eval      = (r_state == ST_SCAN) && r_addr[0] && !start;

    // Descending loops leave the lowest qualifying slot as the final assignment.
    always_comb begin
        w_have_free = 1'b0;
        w_free_idx  = '0;
        w_hit       = 1'b0;
        w_win_idx   = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_have_free = 1'b1;
                w_free_idx  = SW'(i);
            end
            if (r_valid[i] && (r_slot_x[i] == q_x) && (r_state == ST_READY)) begin
                w_hit     = 1'b1;
                w_win_idx = SW'(i);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (start) begin
            w_next_state = ST_SCAN;
        end else if ((r_state == ST_SCAN) && w_last) begin
            w_next_state = ST_READY;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_overflow <= 1'b0;
            r_valid    <= '0;
        end else begin
            r_state <= w_next_state;
            if (start) begin
                r_addr     <= '0;
                r_overflow <= 1'b0;
                r_valid    <= '0;
            end else if (r_state == ST_SCAN) begin
                r_addr <= w_last ? '0 : r_addr + 1'b1;
                if (w_eval && w_visible) begin
                    if (w_have_free) r_valid[w_free_idx] <= 1'b1;
                    else             r_overflow <= 1'b1;
                end
            end else if ((r_state == ST_READY) && q_take && w_hit) begin
                r_valid[w_win_idx] <= 1'b0;
            end
        end
    end

    // NOTE: slot payload is not reset; r_valid alone decides whether a slot's contents mean anything.
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_y     <= oam_d_in[7:0];
            r_x_lat <= oam_d_in[15:8];
        end
        if (w_eval && w_visible && w_have_free) begin
            r_slot_x[w_free_idx]    <= r_x_lat - 8'd8;
            r_slot_data[w_free_idx] <= w_entry;
            r_slot_idx[w_free_idx]  <= w_entry_idx;
        end
    end

    assign oam_addr  = r_addr;
    assign scan_done = (r_state == ST_READY);
    assign overflow  = r_overflow;
    assign hit       = w_hit;
    assign hit_data  = w_hit ? r_slot_data[w_win_idx] : '0;
    assign hit_index = w_hit ? r_slot_idx[w_win_idx] : '0;

endmodule
